data_mem_access_unit: RTL and testbench

- Load/store front end sitting directly upstream of the data RAM (dataRAM).
- Accepts one load or store per cycle from the execute stage via a valid/ready handshake.
- Stores are posted into a small in-order store buffer that drains into the RAM whenever the port is free. Loads have port priority and are forwarded from the buffer on an address hit.
- Every accepted request returns one registered response one cycle later, with out-of-range fault detection.

---
 rtl/galetron_mem_pkg.sv | 38 +++
 rtl/store_buffer_fifo.sv | 84 ++++++++
 rtl/data_mem_access_unit.sv | 137 +++++++++++++
 tb/tb_data_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/galetron_mem_pkg.sv
// -----------------------------------------------------------------------------
// galetron_mem_pkg
// Shared constants, types and helpers for the data-memory access path.
//   DATA_WIDTH       : width of one RAM word
//   ADDR_WIDTH       : width of a word address
//   MEM_WORDS        : number of implemented RAM words (0..MEM_WORDS-1 valid)
//   SB_DEPTH_DEFAULT : default store-buffer depth (power of 2, >= 2)
//   sb_entry_t       : one buffered store {addr, data}
//   port_grant_e     : who owns the RAM port in the current cycle
//   addr_in_range()  : 1 when an address maps onto an implemented RAM word
// -----------------------------------------------------------------------------
package galetron_mem_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ADDR_WIDTH       = 10;
  localparam int MEM_WORDS        = 258;
  localparam int SB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_LOAD  = 2'd1,
    PORT_DRAIN = 2'd2
  } port_grant_e;

  // One extra bit so the limit itself is representable even when
  // MEM_WORDS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] MEM_WORDS_EXT = (ADDR_WIDTH + 1)'(MEM_WORDS);

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return ({1'b0, addr} < MEM_WORDS_EXT);
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// -----------------------------------------------------------------------------
// store_buffer_fifo
// In-order circular store buffer with a youngest-match lookup port.
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-low reset (clears pointers/count)
//   push         in   append push_entry at the tail
//   push_entry   in   store to append
//   pop          in   retire the head entry (caller guarantees non-empty)
//   head_entry   out  oldest buffered store
//   count        out  number of valid entries, 0..DEPTH
//   lookup_addr  in   address to search for
//   lookup_hit   out  1 when any valid entry holds lookup_addr
//   lookup_data  out  data of the youngest matching entry
// -----------------------------------------------------------------------------
module store_buffer_fifo
  import galetron_mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  sb_entry_t               push_entry,
  input  logic                    pop,
  output sb_entry_t               head_entry,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr,
  output logic                    lookup_hit,
  output logic [DATA_WIDTH-1:0]   lookup_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t         entries [DEPTH];
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  tail_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  scan_idx;

  assign count      = count_q;
  assign head_entry = entries[head_ptr];

  // Pointers wrap naturally because DEPTH is a power of two. A push and a
  // pop in the same cycle move both pointers and leave the count alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: validity is tracked by the count alone.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      entries[tail_ptr] <= push_entry;
    end
  end

  // Walk from oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    scan_idx    = head_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entries[scan_idx].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = entries[scan_idx].data;
      end
    end
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
// Load/store front end for the data RAM. Loads own the RAM port when they
// are accepted; otherwise the store buffer drains one entry per cycle.
// Every accepted request gets a registered response one cycle later.
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-low reset
//   reqValid       in   request present
//   reqReady       out  request can be accepted this cycle
//   reqWrite       in   1 = store, 0 = load
//   reqAddress     in   word address
//   reqData        in   store data
//   respValid      out  response for the request accepted last cycle
//   respData       out  load result (0 for stores and faults)
//   respFault      out  request address was outside the RAM
//   sbEmpty        out  store buffer holds no pending stores
//   ramAddress     out  RAM address
//   ramData        out  RAM write data
//   ramWriteEnable out  RAM write strobe
//   ramReadData    in   RAM combinational read data
// -----------------------------------------------------------------------------
module data_mem_access_unit
  import galetron_mem_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic                   reqWrite,
  input  logic [ADDR_WIDTH-1:0]  reqAddress,
  input  logic [DATA_WIDTH-1:0]  reqData,
  output logic                   respValid,
  output logic [DATA_WIDTH-1:0]  respData,
  output logic                   respFault,
  output logic                   sbEmpty,
  output logic [ADDR_WIDTH-1:0]  ramAddress,
  output logic [DATA_WIDTH-1:0]  ramData,
  output logic                   ramWriteEnable,
  input  logic [DATA_WIDTH-1:0]  ramReadData
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;
  localparam logic [CNT_W-1:0] SB_FULL_COUNT = CNT_W'(SB_DEPTH);

  logic                  accept;
  logic                  req_fault;
  logic                  store_push;
  logic                  drain;
  port_grant_e           grant;
  sb_entry_t             push_entry;
  sb_entry_t             head_entry;
  logic [CNT_W-1:0]      sb_count;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] load_data;

  // Handshake and range check. Ready depends only on buffer occupancy, so
  // a full buffer stalls loads too; it is forced low while reset is held.
  assign req_fault  = !addr_in_range(reqAddress);
  assign reqReady   = reset && (sb_count != SB_FULL_COUNT);
  assign accept     = reqValid && reqReady;
  assign store_push = accept && reqWrite && !req_fault;
  assign push_entry = '{addr: reqAddress, data: reqData};
  assign sbEmpty    = (sb_count == '0);

  // Port arbitration: an accepted in-range load wins, otherwise drain the
  // head entry. A faulting load never touches the port, so it lets a drain
  // through. Nothing drains while reset is asserted.
  always_comb begin
    grant = PORT_IDLE;
    if (accept && !reqWrite && !req_fault) begin
      grant = PORT_LOAD;
    end else if (reset && (sb_count != '0)) begin
      grant = PORT_DRAIN;
    end
  end

  assign drain = (grant == PORT_DRAIN);

  // RAM port drive derived from the grant.
  always_comb begin
    ramAddress     = '0;
    ramData        = '0;
    ramWriteEnable = 1'b0;
    case (grant)
      PORT_LOAD: begin
        ramAddress = reqAddress;
      end
      PORT_DRAIN: begin
        ramAddress     = head_entry.addr;
        ramData        = head_entry.data;
        ramWriteEnable = 1'b1;
      end
      default: begin
        ramAddress     = '0;
        ramData        = '0;
        ramWriteEnable = 1'b0;
      end
    endcase
  end

  // A buffered store to the same address is newer than the RAM contents,
  // and no drain happens in a load cycle, so every entry is searchable.
  assign load_data = fwd_hit ? fwd_data : ramReadData;

  // Response register: one response per accepted request, one cycle later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      respValid <= 1'b0;
      respData  <= '0;
      respFault <= 1'b0;
    end else begin
      respValid <= accept;
      respFault <= accept && req_fault;
      respData  <= (grant == PORT_LOAD) ? load_data : '0;
    end
  end

  store_buffer_fifo #(
    .DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clock       (clock),
    .reset       (reset),
    .push        (store_push),
    .push_entry  (push_entry),
    .pop         (drain),
    .head_entry  (head_entry),
    .count       (sb_count),
    .lookup_addr (reqAddress),
    .lookup_hit  (fwd_hit),
    .lookup_data (fwd_data)
  );

endmodule

// File: tb/tb_data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_access_unit
// Self-checking bench: a behavioural RAM, a queue-based reference model of
// the buffered load/store path, directed literal checks and random traffic.
// -----------------------------------------------------------------------------
module tb_data_mem_access_unit;

  localparam int MEM_WORDS = 258;
  localparam int SB_DEPTH  = 4;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } store_t;

  typedef enum { PHASE_DIRECTED, PHASE_RANDOM, PHASE_FINAL } phase_e;

  logic        clock;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [9:0]  reqAddress;
  logic [31:0] reqData;
  logic        respValid;
  logic [31:0] respData;
  logic        respFault;
  logic        sbEmpty;
  logic [9:0]  ramAddress;
  logic [31:0] ramData;
  logic        ramWriteEnable;
  logic [31:0] ramReadData;

  int tests_run    = 0;
  int tests_failed = 0;
  phase_e phase;

  data_mem_access_unit dut (
    .clock          (clock),
    .reset          (reset),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqAddress     (reqAddress),
    .reqData        (reqData),
    .respValid      (respValid),
    .respData       (respData),
    .respFault      (respFault),
    .sbEmpty        (sbEmpty),
    .ramAddress     (ramAddress),
    .ramData        (ramData),
    .ramWriteEnable (ramWriteEnable),
    .ramReadData    (ramReadData)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural data RAM seen by the DUT, combinational read.
  logic [31:0] ram_array [MEM_WORDS];
  assign ramReadData = (int'(ramAddress) < MEM_WORDS) ? ram_array[ramAddress] : 32'h0;

  always @(posedge clock) begin
    if (ramWriteEnable === 1'b1 && int'(ramAddress) < MEM_WORDS) begin
      ram_array[ramAddress] <= ramData;
    end
  end

  // Reference model: pending stores kept in a plain queue, memory contents
  // in a separate array that only ever sees the model's own drains.
  store_t      sbq[$];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        m_live = 1'b0;
  logic        m_resp_valid = 1'b0;
  logic        m_resp_fault = 1'b0;
  logic [31:0] m_resp_data  = 32'h0;
  logic        m_ready;
  logic        m_accept;
  logic        m_fault;
  logic [31:0] m_load;

  always @(posedge clock) begin
    if (reset !== 1'b1) begin
      sbq.delete();
      m_resp_valid = 1'b0;
      m_resp_fault = 1'b0;
      m_resp_data  = 32'h0;
      m_live       = 1'b1;
    end else begin
      m_ready  = (sbq.size() != SB_DEPTH);
      m_accept = reqValid && m_ready;
      m_fault  = (int'(reqAddress) >= MEM_WORDS);
      m_load   = 32'h0;
      if (m_accept && !reqWrite && !m_fault) begin
        m_load = ref_mem[reqAddress];
        foreach (sbq[i]) begin
          if (sbq[i].addr == reqAddress) m_load = sbq[i].data;
        end
      end else if (sbq.size() > 0) begin
        ref_mem[sbq[0].addr] = sbq[0].data;
        void'(sbq.pop_front());
      end
      if (m_accept && reqWrite && !m_fault) begin
        sbq.push_back('{reqAddress, reqData});
      end
      m_resp_valid = m_accept;
      m_resp_fault = m_accept && m_fault;
      m_resp_data  = m_load;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic valid, input logic write,
                               input logic [9:0] addr, input logic [31:0] data);
    @(posedge clock);
    #1;
    reset      = rst;
    reqValid   = valid;
    reqWrite   = write;
    reqAddress = addr;
    reqData    = data;
  endtask

  task automatic waitMid();
    @(negedge clock);
    #1;
  endtask

  // Every-cycle comparison of all outputs against the model.
  logic c_ready;
  logic c_load;

  always @(negedge clock) begin
    if (m_live) begin
      c_ready = (reset === 1'b1) && (sbq.size() != SB_DEPTH);
      c_load  = c_ready && (reqValid === 1'b1) && (reqWrite === 1'b0) && (int'(reqAddress) < MEM_WORDS);
      checkOutput("reqReady", 32'(reqReady), 32'(c_ready));
      checkOutput("sbEmpty", 32'(sbEmpty), 32'(sbq.size() == 0));
      checkOutput("respValid", 32'(respValid), 32'(m_resp_valid));
      checkOutput("respFault", 32'(respFault), 32'(m_resp_fault));
      checkOutput("respData", respData, m_resp_data);
      if (c_load) begin
        checkOutput("ramWriteEnable(load)", 32'(ramWriteEnable), 32'h0);
        checkOutput("ramAddress(load)", 32'(ramAddress), 32'(reqAddress));
      end else if (reset === 1'b1 && sbq.size() > 0) begin
        checkOutput("ramWriteEnable(drain)", 32'(ramWriteEnable), 32'h1);
        checkOutput("ramAddress(drain)", 32'(ramAddress), 32'(sbq[0].addr));
        checkOutput("ramData(drain)", ramData, sbq[0].data);
      end else begin
        checkOutput("ramWriteEnable(idle)", 32'(ramWriteEnable), 32'h0);
        checkOutput("ramAddress(idle)", 32'(ramAddress), 32'h0);
        checkOutput("ramData(idle)", ramData, 32'h0);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    reqValid   = 1'b0;
    reqWrite   = 1'b0;
    reqAddress = '0;
    reqData    = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      ram_array[i] = 32'hC0DE_0000 + 32'(i);
      ref_mem[i]   = 32'hC0DE_0000 + 32'(i);
    end

    phase = PHASE_DIRECTED;
    $display("[TB] entering %s", phase.name());
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 32'h0);

    // Single store, then its drain.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd5, 32'h0000_00AA);
    waitMid();
    checkOutput("lit reqReady after reset", 32'(reqReady), 32'h1);
    checkOutput("lit sbEmpty after reset", 32'(sbEmpty), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit store respValid", 32'(respValid), 32'h1);
    checkOutput("lit store respData", respData, 32'h0);
    checkOutput("lit store respFault", 32'(respFault), 32'h0);
    checkOutput("lit drain we", 32'(ramWriteEnable), 32'h1);
    checkOutput("lit drain addr", 32'(ramAddress), 32'd5);
    checkOutput("lit drain data", ramData, 32'h0000_00AA);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit sbEmpty after drain", 32'(sbEmpty), 32'h1);

    // Two stores to one address then a load: youngest value forwarded.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd7, 32'h11);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd7, 32'h22);
    waitMid();
    checkOutput("lit first drain data", ramData, 32'h11);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd7, 32'h0);
    waitMid();
    checkOutput("lit load blocks drain", 32'(ramWriteEnable), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit forwarded load", respData, 32'h22);
    checkOutput("lit second drain data", ramData, 32'h22);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit ram[7]", ram_array[7], 32'h22);

    // Out-of-range requests and the last valid address.
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd258, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd1023, 32'hDEAD_BEEF);
    waitMid();
    checkOutput("lit load fault", 32'(respFault), 32'h1);
    checkOutput("lit load fault data", respData, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd257, 32'h0);
    waitMid();
    checkOutput("lit store fault", 32'(respFault), 32'h1);
    checkOutput("lit store fault not buffered", 32'(sbEmpty), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit load 257 no fault", 32'(respFault), 32'h0);
    checkOutput("lit load 257 data", respData, 32'hC0DE_0101);

    // Reset discards a buffered store.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd9, 32'h5A5A_5A5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit no write in reset", 32'(ramWriteEnable), 32'h0);
    checkOutput("lit not ready in reset", 32'(reqReady), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit sbEmpty after reset", 32'(sbEmpty), 32'h1);
    checkOutput("lit respValid after reset", 32'(respValid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd9, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit discarded store", respData, 32'hC0DE_0009);

    // Store stream long enough to wrap the buffer pointers.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd3, 32'd100 + 32'(i));
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd3, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    checkOutput("lit wrap forward", respData, 32'd105);

    phase = PHASE_RANDOM;
    $display("[TB] entering %s", phase.name());
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst;
      logic [9:0]  r_addr;
      int unsigned sel;
      r_rst = ($urandom_range(99, 0) != 0);
      sel   = $urandom_range(9, 0);
      if (sel < 6)      r_addr = 10'($urandom_range(15, 0));
      else if (sel < 8) r_addr = 10'($urandom_range(265, 250));
      else              r_addr = 10'($urandom_range(1023, 0));
      applyStimulus(r_rst, ($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1,
                    r_addr, $urandom);
    end

    phase = PHASE_FINAL;
    $display("[TB] entering %s", phase.name());
    repeat (SB_DEPTH + 2) applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'h0);
    waitMid();
    for (int i = 0; i < MEM_WORDS; i++) begin
      checkOutput("final ram contents", ram_array[i], ref_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
